// File: rtl/program_counter.sv
// MC14500B instruction-address generator: program counter with a circular
// return-address stack serving the ICU's JMP/RTN flags.
module program_counter #(
  parameter int unsigned           ADDR_WIDTH   = 8,
  parameter int unsigned           STACK_DEPTH  = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pc_reset,
  input  logic                           step,
  input  logic                           jmp,
  input  logic                           link,
  input  logic                           rtn,
  input  logic [ADDR_WIDTH-1:0]          jmp_addr,
  output logic [ADDR_WIDTH-1:0]          pc,
  output logic                           skip,
  output logic [$clog2(STACK_DEPTH):0]   depth,
  output logic                           overflow,
  output logic                           underflow
);

  localparam int unsigned PW = $clog2(STACK_DEPTH);
  localparam int unsigned DW = PW + 1;
  localparam logic [DW-1:0] FULL = DW'(STACK_DEPTH);

  logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];

  logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_inc;
  logic                  skip_q, skip_d;
  logic [DW-1:0]         depth_q, depth_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [PW-1:0]         top_q, top_d, wr_ptr;
  logic                  push_en;

  assign pc_inc = pc_q + ADDR_WIDTH'(1);
  assign wr_ptr = top_q + PW'(1);

  always_comb begin
    pc_d    = pc_q;
    skip_d  = skip_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    top_d   = top_q;
    push_en = 1'b0;
    if (pc_reset) begin
      pc_d    = RESET_VECTOR;
      skip_d  = 1'b0;
      depth_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      top_d   = '0;
    end else if (step) begin
      skip_d = 1'b0;
      if (rtn) begin
        if (depth_q != '0) begin
          pc_d    = stack_q[top_q];
          depth_d = depth_q - DW'(1);
          top_d   = top_q - PW'(1);
          skip_d  = 1'b1;
        end else begin
          pc_d  = pc_inc;
          unf_d = 1'b1;
        end
      end else if (jmp) begin
        pc_d = jmp_addr;
        if (link) begin
          // When full, the slot after top holds the oldest entry, so the
          // push overwrites it naturally.
          push_en = 1'b1;
          top_d   = wr_ptr;
          if (depth_q == FULL) ovf_d = 1'b1;
          else                 depth_d = depth_q + DW'(1);
        end
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_VECTOR;
      skip_q  <= 1'b0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      top_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      skip_q  <= skip_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      top_q   <= top_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) stack_q[wr_ptr] <= pc_inc;
  end

  assign pc        = pc_q;
  assign skip      = skip_q;
  assign depth     = depth_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- Instruction-address generator for the MC14500B core. It is the consuming end of the `pc_reset` line driven by the reset sequencer.
- Holds the program counter and advances it once per instruction step.
- Services the ICU's JMP/RTN flag outputs through a small internal return-address stack.
- Drives the program-ROM address and a skip indication back to the ICU.

Parameters:
- ADDR_WIDTH, 8, width of the program counter and of all stored addresses.
- STACK_DEPTH, 4, number of return-address entries (power of two, ≥2).
- RESET_VECTOR, 0, value loaded into `pc` on any reset.

Ports:
- clk  input  1  system clock; all state updates occur on the rising edge.
- rst  input  1  asynchronous, active-high reset; clears all state immediately.
- pc_reset  input  1  synchronous clear from the reset sequencer; sampled on the rising edge.
- step  input  1  instruction-advance enable; state changes only when high (except resets).
- jmp  input  1  ICU JMP flag for this instruction.
- link  input  1  qualifies `jmp`: push the return address before jumping.
- rtn  input  1  ICU RTN flag for this instruction.
- jmp_addr  input  ADDR_WIDTH  jump target (instruction operand field).
- pc  output  ADDR_WIDTH  current instruction address.
- skip  output  1  high for exactly one step after a successful return; the ICU suppresses that instruction.
- depth  output  clog2(STACK_DEPTH)+1  number of valid stack entries.
- overflow  output  1  sticky; set when a push occurs with the stack full.
- underflow  output  1  sticky; set when `rtn` occurs with the stack empty.

Behaviour:
- Reset values, for both `rst` and `pc_reset`:
  - `pc` = RESET_VECTOR.
  - `skip` = 0, `depth` = 0, `overflow` = 0, `underflow` = 0.
  - Stack contents are don't-care.
- Reset behaviour:
  - `rst` acts asynchronously.
  - `pc_reset` acts on the next rising edge regardless of `step`.
  - `pc_reset` overrides every other input in that cycle.
- Hold: with `step` = 0 and no reset, all state and outputs hold, including `skip`.
- Action on a rising edge with `step` = 1, in priority order:
  1. `rtn` = 1, stack non-empty:
     - `pc` ← top entry; `depth` − 1.
     - `skip` ← 1.
     - `jmp` and `link` are ignored.
  2. `rtn` = 1, stack empty:
     - `pc` ← `pc` + 1; `underflow` ← 1.
     - `skip` ← 0; `depth` unchanged.
  3. `jmp` = 1, `link` = 1:
     - Push `pc` + 1 (mod 2^ADDR_WIDTH); `pc` ← `jmp_addr`; `skip` ← 0.
     - If not full: `depth` + 1.
     - If full: the oldest entry is discarded (circular buffer), `depth` stays at STACK_DEPTH, and `overflow` ← 1.
  4. `jmp` = 1, `link` = 0: `pc` ← `jmp_addr`; stack untouched; `skip` ← 0.
  5. Otherwise: `pc` ← `pc` + 1; `skip` ← 0.
- Arithmetic: the increment wraps modulo 2^ADDR_WIDTH (all-ones → 0); no flag is raised on wrap.
- Skip timing:
  - `skip` is registered and valid in the cycle `pc` shows the return address.
  - It clears on the next stepped edge.
- Stack organisation:
  - Stack is LIFO; implemented as circular storage with a top pointer plus a `depth` counter.
  - A pop after overflow returns the most recent STACK_DEPTH pushes in reverse order.
- Sticky flags: `overflow` and `underflow` clear only on `rst` or `pc_reset`.
- Latency: all outputs are registered; one edge from a stepped input to the updated output; no combinational input→output paths.

Test Plan:
- Apply `rst` mid-cycle while `pc` = 0x37 → `pc` = 0x00 and `depth` = 0 before the next edge. With `step` = 1 and no flags for 3 edges → `pc` = 0x03.
- `pc` = 0x10: `jmp` = 1, `link` = 1, `jmp_addr` = 0x80 → `pc` = 0x80, `depth` = 1. Then 2 plain steps, then `rtn` → `pc` = 0x11, `skip` = 1. Next step → `pc` = 0x12, `skip` = 0.
- Five nested linked jumps from `pc` = 0x00, 0x20, 0x40, 0x60, 0x80, each targeting +0x20:
  - After the 5th push → `overflow` = 1, `depth` = 4.
  - Four `rtn`s → `pc` = 0x81, 0x61, 0x41, 0x21.
  - A fifth `rtn` → `underflow` = 1, `pc` increments.
- `pc` = 0xFF with a plain step → `pc` = 0x00, no flags. Also: `rtn` and `jmp` asserted together with `depth` = 1 → return taken, `jmp_addr` ignored.
- Assert `pc_reset` with `step` = 0 while `depth` = 3 and `overflow` = 1 → after one edge `pc` = 0x00, `depth` = 0, `overflow` = 0.
- Toggle `step` = 0 for 5 cycles while `jmp` = 1 → `pc`, `depth` and `skip` are unchanged throughout.
